// File: rtl/parallel_in_serial_out_if.sv
`default_nettype none
// ============================================================================
//  Module   : parallel_in_serial_out_if
//  Purpose  : Load handshake and serial-link bundle for parallel_in_serial_out.
//             The master is the word producer; the slave is the serialiser.
//  Revision : 1.0 - initial release
// ============================================================================
interface parallel_in_serial_out_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] parallel_in;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic             serial_valid;
    logic             busy;
    logic             frame_done;

    modport master (
        output parallel_in,
        output load_valid,
        input  load_ready,
        input  serial_out,
        input  serial_valid,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  parallel_in,
        input  load_valid,
        output load_ready,
        output serial_out,
        output serial_valid,
        output busy,
        output frame_done
    );
endinterface
`default_nettype wire

// File: rtl/parallel_in_serial_out.sv
`default_nettype none
// ============================================================================
//  Module   : parallel_in_serial_out
//  Purpose  : Accepts a WIDTH-bit word on a valid/ready handshake and shifts
//             it out one bit per clock, framed by serial_valid. A word offered
//             during the last bit of a frame is taken without a gap.
//  Revision : 1.0 - initial release
// ============================================================================
module parallel_in_serial_out #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire                      clk,
    input  wire                      reset,
    parallel_in_serial_out_if.slave  bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;

    logic             w_shifting;
    logic             w_last;
    logic             w_ready;
    logic             w_accept;
    logic             w_end_bit;
    logic [WIDTH-1:0] w_shift_next;

    // Bit order only changes which end of the register is on the wire and
    // which way it moves; the FSM and counter are identical for both orders.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_end_bit    = r_shift[WIDTH-1];
            assign w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_end_bit    = r_shift[0];
            assign w_shift_next = {1'b0, r_shift[WIDTH-1:1]};
        end
    endgenerate

    // Handshake and status decode; ready reopens on the last bit so
    // back-to-back frames need no idle cycle.
    always_comb begin
        w_shifting = (r_state == S_SHIFT);
        w_last     = w_shifting && (r_cnt == C_LAST);
        w_ready    = (r_state == S_IDLE) || w_last;
        w_accept   = bus.load_valid && w_ready;
    end

    assign bus.load_ready   = w_ready;
    assign bus.serial_out   = w_shifting ? w_end_bit : 1'b0;
    assign bus.serial_valid = w_shifting;
    assign bus.busy         = w_shifting;
    assign bus.frame_done   = w_last;

    // FSM, shift register and bit counter; an accepted word always restarts
    // the frame, otherwise the register shifts once per SHIFT cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_state <= S_SHIFT;
            r_shift <= bus.parallel_in;
            r_cnt   <= '0;
        end else if (w_shifting) begin
            r_shift <= w_shift_next;
            if (w_last) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parallel_in_serial_out.sv
`default_nettype none
// ============================================================================
//  Module   : tb_parallel_in_serial_out
//  Purpose  : Directed self-checking bench for parallel_in_serial_out with a
//             serial-bit scoreboard (WIDTH=4 MSB-first) and a WIDTH=8
//             LSB-first instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_parallel_in_serial_out;

    logic clk;
    logic reset;

    parallel_in_serial_out_if #(.WIDTH(4)) bus4 ();
    parallel_in_serial_out_if #(.WIDTH(8)) bus8 ();

    parallel_in_serial_out #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    parallel_in_serial_out #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic last;
    } sb_t;

    sb_t  q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic [3:0] r_sipo;

    // Receiver model: MSB-first SIPO enabled by serial_valid.
    always @(posedge clk or negedge reset) begin
        if (!reset)                 r_sipo <= 4'h0;
        else if (bus4.serial_valid) r_sipo <= {r_sipo[2:0], bus4.serial_out};
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) q.push_back('{b: w[i], last: (i == 0)});
    endtask

    task automatic tick(input logic exp_valid);
        sb_t e;
        @(posedge clk);
        #1;
        chk("serial_valid", {7'd0, bus4.serial_valid}, {7'd0, exp_valid});
        chk("busy", {7'd0, bus4.busy}, {7'd0, exp_valid});
        if (exp_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $error("FAIL scoreboard: observed bit with empty queue expected none");
            end else begin
                e = q.pop_front();
                chk("serial_out", {7'd0, bus4.serial_out}, {7'd0, e.b});
                chk("frame_done", {7'd0, bus4.frame_done}, {7'd0, e.last});
            end
        end else begin
            chk("idle_serial_out", {7'd0, bus4.serial_out}, 8'd0);
            chk("idle_frame_done", {7'd0, bus4.frame_done}, 8'd0);
        end
    endtask

    task automatic load(input logic [3:0] w);
        bus4.parallel_in = w;
        bus4.load_valid  = 1'b1;
        chk("load_ready", {7'd0, bus4.load_ready}, 8'd1);
        push_word(w);
        tick(1'b1);
        bus4.load_valid  = 1'b0;
        bus4.parallel_in = 4'($urandom);
    endtask

    initial begin
        logic [7:0] exp8;
        reset = 1'b0;
        bus4.parallel_in = 4'h0;
        bus4.load_valid  = 1'b0;
        bus8.parallel_in = 8'h00;
        bus8.load_valid  = 1'b0;

        // 1. Reset values, X-free
        #15;
        chk("rst_serial_out", {7'd0, bus4.serial_out}, 8'd0);
        chk("rst_serial_valid", {7'd0, bus4.serial_valid}, 8'd0);
        chk("rst_busy", {7'd0, bus4.busy}, 8'd0);
        chk("rst_frame_done", {7'd0, bus4.frame_done}, 8'd0);
        chk("rst_load_ready", {7'd0, bus4.load_ready}, 8'd1);
        chk("rst8_load_ready", {7'd0, bus8.load_ready}, 8'd1);
        @(negedge clk);
        reset = 1'b1;
        tick(1'b0);

        // 2. Single frame 1001 with SIPO loopback
        load(4'b1001);
        tick(1'b1); tick(1'b1); tick(1'b1);
        tick(1'b0);
        chk("sipo_word", {4'd0, r_sipo}, 8'h09);

        // 3. Back-to-back 1001 then 0110
        load(4'b1001);
        tick(1'b1); tick(1'b1); tick(1'b1);
        load(4'b0110);
        tick(1'b1); tick(1'b1); tick(1'b1);
        tick(1'b0);
        chk("b2b_queue_empty", 8'(q.size()), 8'd0);

        // 4. Load attempt during bit 1 is ignored
        load(4'b1100);
        tick(1'b1);
        bus4.parallel_in = 4'b0011;
        bus4.load_valid  = 1'b1;
        chk("busy_load_ready", {7'd0, bus4.load_ready}, 8'd0);
        tick(1'b1);
        bus4.load_valid  = 1'b0;
        tick(1'b1);
        tick(1'b0);
        chk("busy_queue_empty", 8'(q.size()), 8'd0);

        // 5. Mid-frame asynchronous reset
        load(4'b1010);
        tick(1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_serial_valid", {7'd0, bus4.serial_valid}, 8'd0);
        chk("mid_rst_serial_out", {7'd0, bus4.serial_out}, 8'd0);
        chk("mid_rst_busy", {7'd0, bus4.busy}, 8'd0);
        chk("mid_rst_load_ready", {7'd0, bus4.load_ready}, 8'd1);
        q.delete();
        tick(1'b0);
        reset = 1'b1;
        tick(1'b0);
        load(4'b1010);
        tick(1'b1); tick(1'b1); tick(1'b1);
        tick(1'b0);
        chk("post_rst_sipo", {4'd0, r_sipo}, 8'h0A);

        // 6. WIDTH=8, LSB first: 8'hA5
        exp8 = 8'hA5;
        bus8.parallel_in = exp8;
        bus8.load_valid  = 1'b1;
        chk("w8_load_ready", {7'd0, bus8.load_ready}, 8'd1);
        @(posedge clk);
        #1;
        bus8.load_valid  = 1'b0;
        bus8.parallel_in = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            chk("w8_serial_valid", {7'd0, bus8.serial_valid}, 8'd1);
            chk("w8_serial_out", {7'd0, bus8.serial_out}, {7'd0, exp8[i]});
            chk("w8_frame_done", {7'd0, bus8.frame_done}, {7'd0, (i == 7)});
            @(posedge clk);
            #1;
        end
        chk("w8_idle_valid", {7'd0, bus8.serial_valid}, 8'd0);
        chk("w8_idle_busy", {7'd0, bus8.busy}, 8'd0);
        chk("w8_idle_ready", {7'd0, bus8.load_ready}, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
